writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Producer side of the register-file writeback interface.
- Collects results from two execution-side channels: A = fixed-point/branch, B = load/store.
- Buffers the results in an in-order FIFO and drives the register unit's two writeback ports (reg1*/reg2*) each cycle.
- Retires up to two entries per cycle, never issuing two writes to the same register address in one cycle.

Parameters:
- DEPTH, 4, FIFO entries (minimum 2).
- ADDR_W, 5, GPR address width.
- DATA_W, 64, writeback data width.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-low.
- resAValid_i  in  1  channel A result valid.
- resAAddress_i  in  ADDR_W  channel A destination register.
- resAData_i  in  DATA_W  channel A result.
- resAReady_o  out  1  channel A may present a result.
- resBValid_i  in  1  channel B result valid.
- resBAddress_i  in  ADDR_W  channel B destination register.
- resBData_i  in  DATA_W  channel B result.
- resBReady_o  out  1  channel B may present a result.
- reg1WritebackData_o  out  DATA_W  port-1 data to the register unit.
- reg1WritebackAddress_o  out  ADDR_W  port-1 address.
- reg1isWriteback_o  out  1  port-1 write enable.
- reg2WritebackData_o  out  DATA_W  port-2 data.
- reg2WritebackAddress_o  out  ADDR_W  port-2 address.
- reg2isWriteback_o  out  1  port-2 write enable.
- pendingCount_o  out  clog2(DEPTH+1)  current FIFO occupancy.
- empty_o  out  1  FIFO empty.

Behaviour:
- Reset (async, reset_i=0):
  - FIFO pointers and count cleared; entries discarded.
  - All writeback outputs 0; pendingCount_o=0; empty_o=1; resAReady_o=resBReady_o=1.
  - Takes effect immediately, including mid-operation; in-flight results are lost.
- Ready, combinational from the registered count only (no same-cycle credit from dequeue):
  - resAReady_o = (count <= DEPTH-1).
  - resBReady_o = (count <= DEPTH-2).
- Enqueue:
  - A transfer occurs at the rising edge when valid=1 and ready=1.
  - If A and B both transfer in the same cycle, A is written at tail and B at tail+1, so A retires first.
  - Valid while not ready: no transfer; the producer holds its inputs.
- Dequeue, evaluated on count at the start of the cycle:
  - Port 1: if count>=1, head is loaded into reg1 outputs with reg1isWriteback_o=1; else reg1isWriteback_o=0.
  - Port 2: if count>=2 and head+1 address != head address, head+1 is loaded into reg2 outputs with reg2isWriteback_o=1; else reg2isWriteback_o=0 and head+1 stays queued for the next cycle.
  - The register unit never back-pressures; every asserted writeback is consumed that cycle.
- Writeback outputs are registered and hold for exactly one cycle.
  - Data and address outputs hold their last value when the enable is 0.
  - Checks may only rely on them when the enable is 1.
- Latency: a result enqueued at edge N is at the head no earlier than after N, and drives the writeback port after edge N+1.
- Simultaneous enqueue and dequeue: count_next = count + enqA + enqB - deq (deq 0..2).
  - Pointers wrap from DEPTH-1 to 0.
  - Full (count=DEPTH): both ready low; draining continues.
  - Empty: no writes issued.
- Ordering: retirement is strictly in enqueue order; port 1 is always the older entry.
- Address 0 is written like any other register; there is no special zero handling.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When count=0 and channel A (else B) transfers, that result is loaded directly into reg1 outputs at the same edge, bypassing the FIFO.
  - If both A and B transfer with distinct addresses, both bypass: A to port 1, B to port 2.
  - If the addresses are equal, only A bypasses and B enqueues.
  - Latency becomes 1 edge.
- Undefined: all results pass through the FIFO; latency is 2 edges as above.

Test Plan:
- Reset then idle: after reset_i pulse low, all is*Writeback_o=0, empty_o=1, pendingCount_o=0, both ready=1.
- Single result: A (addr 5, data 10) one cycle.
  - Without bypass: reg1 addr 5 / data 10 / en 1 after the second edge, for one cycle.
  - With WB_BYPASS_EN: after the first edge.
- Dual retire: A (addr 2, data 5) and B (addr 3, data 6) same cycle -> next cycle port1=2/5 and port2=3/6, both enables 1.
- Same-address conflict: A and B both addr 7 (data 1, 2) -> port1 7/1 with port2 disabled, then the following cycle port1 7/2.
- Full/back-pressure: hold A and B valid with distinct addresses for 4 cycles (DEPTH=4).
  - Verify resBReady_o falls at count>=3 and resAReady_o at count=4.
  - No entries lost; retirement order matches enqueue order.
- Reset mid-operation: fill 3 entries, assert reset_i low between edges -> outputs clear immediately, no writeback issued after release, count=0.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: producer side of the register-file writeback interface.
//
// Collects results from channel A (fixed-point/branch) and channel B (load/store),
// buffers them in an in-order FIFO and retires up to two entries per cycle onto the
// register unit's two writeback ports. Two writes to the same register are never
// issued in one cycle; port 1 always carries the older entry.
//
// Ports:
//   clock_i, reset_i (async, active-low)
//   resA*/resB*       : result channels (valid/address/data in, ready out)
//   reg1*/reg2*       : registered writeback ports (data/address/enable)
//   pendingCount_o    : FIFO occupancy
//   empty_o           : FIFO empty
//
// Optional feature: define WB_BYPASS_EN to let results arriving at an empty FIFO go
// straight to the writeback ports at the same edge (one-edge latency).
module writeback_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       resAValid_i,
  input  logic [ADDR_W-1:0]          resAAddress_i,
  input  logic [DATA_W-1:0]          resAData_i,
  output logic                       resAReady_o,
  input  logic                       resBValid_i,
  input  logic [ADDR_W-1:0]          resBAddress_i,
  input  logic [DATA_W-1:0]          resBData_i,
  output logic                       resBReady_o,
  output logic [DATA_W-1:0]          reg1WritebackData_o,
  output logic [ADDR_W-1:0]          reg1WritebackAddress_o,
  output logic                       reg1isWriteback_o,
  output logic [DATA_W-1:0]          reg2WritebackData_o,
  output logic [ADDR_W-1:0]          reg2WritebackAddress_o,
  output logic                       reg2isWriteback_o,
  output logic [$clog2(DEPTH+1)-1:0] pendingCount_o,
  output logic                       empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointer advance with wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [1:0]       inc);
    int unsigned sum;
    sum = 32'(ptr) + 32'(inc);
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PTR_W'(sum);
  endfunction

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt, tail_b;
  logic [CNT_W-1:0] count_q, count_d;

  logic enq_a, enq_b, wr_a, wr_b, deq1, deq2;
  logic [1:0] n_enq, n_deq;

  logic              wb1_en_d, wb1_en_q, wb2_en_d, wb2_en_q;
  logic [ADDR_W-1:0] wb1_addr_d, wb1_addr_q, wb2_addr_d, wb2_addr_q;
  logic [DATA_W-1:0] wb1_data_d, wb1_data_q, wb2_data_d, wb2_data_q;

  // Ready depends only on the registered count: no credit for same-cycle retirement.
  assign resAReady_o = (count_q <= CNT_W'(DEPTH - 1));
  assign resBReady_o = (count_q <= CNT_W'(DEPTH - 2));

  assign enq_a = resAValid_i & resAReady_o;
  assign enq_b = resBValid_i & resBReady_o;

  assign head_nxt = ptr_add(head_q, 2'd1);
  assign deq1     = (count_q != '0);
  // Port 2 only retires when it cannot collide with port 1 on the register address.
  assign deq2     = (count_q >= CNT_W'(2)) && (addr_mem[head_nxt] != addr_mem[head_q]);

  always_comb begin
    wr_a       = enq_a;
    wr_b       = enq_b;
    wb1_en_d   = deq1;
    wb1_addr_d = addr_mem[head_q];
    wb1_data_d = data_mem[head_q];
    wb2_en_d   = deq2;
    wb2_addr_d = addr_mem[head_nxt];
    wb2_data_d = data_mem[head_nxt];
`ifdef WB_BYPASS_EN
    // Empty FIFO: nothing is retiring, so incoming results may take the ports directly.
    if (count_q == '0) begin
      if (enq_a) begin
        wr_a       = 1'b0;
        wb1_en_d   = 1'b1;
        wb1_addr_d = resAAddress_i;
        wb1_data_d = resAData_i;
        if (enq_b && (resBAddress_i != resAAddress_i)) begin
          wr_b       = 1'b0;
          wb2_en_d   = 1'b1;
          wb2_addr_d = resBAddress_i;
          wb2_data_d = resBData_i;
        end
      end else if (enq_b) begin
        wr_b       = 1'b0;
        wb1_en_d   = 1'b1;
        wb1_addr_d = resBAddress_i;
        wb1_data_d = resBData_i;
      end
    end
`endif
  end

  assign n_enq   = {1'b0, wr_a} + {1'b0, wr_b};
  assign n_deq   = {1'b0, deq1} + {1'b0, deq2};
  assign tail_b  = wr_a ? ptr_add(tail_q, 2'd1) : tail_q;
  assign head_d  = ptr_add(head_q, n_deq);
  assign tail_d  = ptr_add(tail_q, n_enq);
  assign count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock_i) begin
    if (wr_a) begin
      addr_mem[tail_q] <= resAAddress_i;
      data_mem[tail_q] <= resAData_i;
    end
    if (wr_b) begin
      addr_mem[tail_b] <= resBAddress_i;
      data_mem[tail_b] <= resBData_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wb1_en_q   <= 1'b0;
      wb1_addr_q <= '0;
      wb1_data_q <= '0;
      wb2_en_q   <= 1'b0;
      wb2_addr_q <= '0;
      wb2_data_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wb1_en_q <= wb1_en_d;
      wb2_en_q <= wb2_en_d;
      // Address/data hold their last value while the enable is low.
      if (wb1_en_d) begin
        wb1_addr_q <= wb1_addr_d;
        wb1_data_q <= wb1_data_d;
      end
      if (wb2_en_d) begin
        wb2_addr_q <= wb2_addr_d;
        wb2_data_q <= wb2_data_d;
      end
    end
  end

  assign reg1isWriteback_o      = wb1_en_q;
  assign reg1WritebackAddress_o = wb1_addr_q;
  assign reg1WritebackData_o    = wb1_data_q;
  assign reg2isWriteback_o      = wb2_en_q;
  assign reg2WritebackAddress_o = wb2_addr_q;
  assign reg2WritebackData_o    = wb2_data_q;
  assign pendingCount_o         = count_q;
  assign empty_o                = (count_q == '0);

endmodule
